seg7_letter_decoder: RTL and testbench

SEG7_LETTER_DECODER -- requirements
Module: seg7_letter_decoder

---
 rtl/seg7_letter_decoder.sv | 136 +++++++++++++
 tb/tb_seg7_letter_decoder.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/seg7_letter_decoder.sv
// seg7_letter_decoder: debounces an active-low 7-segment pattern and decodes it to a letter code with step checking
module seg7_letter_decoder #(
   parameter int STABLE_CYCLES = 4
) (
   input  logic       CLOCK_50,
   input  logic       RESET,
   input  logic [0:6] SEG_IN,
   input  logic       SEG_VALID,
   output logic [4:0] LETTER,
   output logic       LETTER_VALID,
   output logic       UNKNOWN,
   output logic       AMBIG,
   output logic       STEP_OK,
   output logic       SEQ_ERR,
   output logic [7:0] LETTER_COUNT
);
   typedef enum logic [1:0] {IDLE, FILTER, EMIT, HOLD} state_t;
   localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);
   state_t     state;
   logic [0:6] cand;
   logic [0:6] last_pat;
   logic [3:0] cnt;
   logic       have_last;
   logic       have_ref;
   logic [4:0] ref_letter;
   logic [4:0] lo_code;
   logic [4:0] hi_code;
   logic [4:0] code;
   logic       known;
   logic       dual;
   logic       step_ok;
   // table lookup of the candidate; shared patterns report the lower code and flag dual
   always_comb begin
      known   = 1'b1;
      dual    = 1'b0;
      lo_code = 5'd0;
      case (cand)
         7'b1111111: lo_code = 5'd0;
         7'b0001000: lo_code = 5'd1;
         7'b1100000: begin lo_code = 5'd2; dual = 1'b1; end
         7'b0110001: lo_code = 5'd3;
         7'b1000010: lo_code = 5'd4;
         7'b0110000: lo_code = 5'd5;
         7'b0111000: lo_code = 5'd6;
         7'b0100000: lo_code = 5'd7;
         7'b1001000: begin lo_code = 5'd8; dual = 1'b1; end
         7'b1001111: lo_code = 5'd9;
         7'b1000011: lo_code = 5'd10;
         7'b1110001: lo_code = 5'd11;
         7'b0101011: lo_code = 5'd12;
         7'b1101010: lo_code = 5'd13;
         7'b0000001: lo_code = 5'd14;
         7'b0011000: lo_code = 5'd15;
         7'b0001100: lo_code = 5'd16;
         7'b1111010: lo_code = 5'd17;
         7'b0100100: lo_code = 5'd18;
         7'b1000001: lo_code = 5'd20;
         7'b1100011: lo_code = 5'd21;
         7'b1010101: lo_code = 5'd22;
         7'b1000100: lo_code = 5'd24;
         7'b0010010: lo_code = 5'd25;
         default:    known = 1'b0;
      endcase
   end
   // ambiguous patterns take the higher code only when it continues the sequence
   always_comb begin
      hi_code = (lo_code == 5'd2) ? 5'd19 : 5'd23;
      code    = (dual && have_ref && (ref_letter + 5'd1 == hi_code)) ? hi_code : lo_code;
      step_ok = (code == ref_letter + 5'd1) || (ref_letter == 5'd25 && code == 5'd1);
   end
   // filter FSM with registered decode results and one-cycle pulses
   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         state        <= IDLE;
         cand         <= '0;
         last_pat     <= '0;
         cnt          <= '0;
         have_last    <= 1'b0;
         have_ref     <= 1'b0;
         ref_letter   <= '0;
         LETTER       <= '0;
         LETTER_VALID <= 1'b0;
         UNKNOWN      <= 1'b0;
         AMBIG        <= 1'b0;
         STEP_OK      <= 1'b0;
         SEQ_ERR      <= 1'b0;
         LETTER_COUNT <= '0;
      end else begin
         LETTER_VALID <= 1'b0;
         UNKNOWN      <= 1'b0;
         AMBIG        <= 1'b0;
         STEP_OK      <= 1'b0;
         SEQ_ERR      <= 1'b0;
         case (state)
            IDLE: if (SEG_VALID) begin
               cand  <= SEG_IN;
               cnt   <= 4'd1;
               state <= FILTER;
            end
            FILTER: if (cnt == STABLE) begin
               state <= (!have_last || cand != last_pat) ? EMIT : HOLD;
            end else if (SEG_VALID) begin
               cand <= SEG_IN;
               cnt  <= (SEG_IN == cand) ? cnt + 4'd1 : 4'd1;
            end
            EMIT: begin
               last_pat  <= cand;
               have_last <= 1'b1;
               state     <= HOLD;
               if (!known) begin
                  UNKNOWN <= 1'b1;
               end else begin
                  LETTER_VALID <= 1'b1;
                  LETTER       <= code;
                  AMBIG        <= dual;
                  if (code == 5'd0) begin
                     have_ref <= 1'b0;
                  end else begin
                     STEP_OK      <= have_ref && step_ok;
                     SEQ_ERR      <= have_ref && !step_ok;
                     have_ref     <= 1'b1;
                     ref_letter   <= code;
                     LETTER_COUNT <= (LETTER_COUNT == 8'hFF) ? LETTER_COUNT : LETTER_COUNT + 8'd1;
                  end
               end
            end
            HOLD: if (SEG_VALID && SEG_IN != last_pat) begin
               cand  <= SEG_IN;
               cnt   <= 4'd1;
               state <= FILTER;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_seg7_letter_decoder.sv
// tb_seg7_letter_decoder: directed vectors for the letter decoder
module tb_seg7_letter_decoder;
   logic       CLOCK_50 = 1'b0;
   logic       RESET = 1'b1;
   logic [0:6] SEG_IN = 7'b1111111;
   logic       SEG_VALID = 1'b0;
   logic [4:0] LETTER;
   logic       LETTER_VALID, UNKNOWN, AMBIG, STEP_OK, SEQ_ERR;
   logic [7:0] LETTER_COUNT;
   int n_chk = 0, n_pass = 0;
   int lv, unk, ok, err, amb;
   localparam logic [0:6] P_A = 7'b0001000, P_BT = 7'b1100000, P_C = 7'b0110001,
      P_E = 7'b0110000, P_F = 7'b0111000, P_G = 7'b0100000, P_HX = 7'b1001000,
      P_I = 7'b1001111, P_J = 7'b1000011, P_S = 7'b0100100, P_W = 7'b1010101,
      P_Z = 7'b0010010, P_BLANK = 7'b1111111, P_BAD = 7'b0000000;
   seg7_letter_decoder #(.STABLE_CYCLES(4)) dut (
      .CLOCK_50(CLOCK_50), .RESET(RESET), .SEG_IN(SEG_IN), .SEG_VALID(SEG_VALID),
      .LETTER(LETTER), .LETTER_VALID(LETTER_VALID), .UNKNOWN(UNKNOWN), .AMBIG(AMBIG),
      .STEP_OK(STEP_OK), .SEQ_ERR(SEQ_ERR), .LETTER_COUNT(LETTER_COUNT)
   );
   always #5 CLOCK_50 = ~CLOCK_50;
   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask
   task automatic tick();
      @(posedge CLOCK_50);
      #1;
      lv  = lv + int'(LETTER_VALID);
      unk = unk + int'(UNKNOWN);
      ok  = ok + int'(STEP_OK);
      err = err + int'(SEQ_ERR);
      amb = amb + int'(AMBIG);
   endtask
   task automatic clr();
      lv = 0; unk = 0; ok = 0; err = 0; amb = 0;
   endtask
   task automatic drive(input logic [0:6] p, input int n);
      SEG_IN = p;
      SEG_VALID = 1'b1;
      repeat (n) tick();
      SEG_VALID = 1'b0;
   endtask
   task automatic letter(input logic [0:6] p);
      clr();
      drive(p, 4);
      repeat (3) tick();
   endtask
   initial begin
      logic [6:0] gaps;
      clr();
      #12;
      check("rst_letter", int'(LETTER), 0);
      check("rst_count", int'(LETTER_COUNT), 0);
      check("rst_pulses", int'({LETTER_VALID, UNKNOWN, AMBIG, STEP_OK, SEQ_ERR}), 0);
      @(posedge CLOCK_50); #1;
      RESET = 1'b0;
      SEG_IN = P_A;
      SEG_VALID = 1'b1;
      clr();
      repeat (5) tick();
      check("lat_early", lv, 0);
      tick();
      check("lat_pulse", int'(LETTER_VALID), 1);
      check("lat_letter", int'(LETTER), 1);
      check("lat_stepok", int'(STEP_OK), 0);
      check("lat_count", int'(LETTER_COUNT), 1);
      clr();
      repeat (100) tick();
      check("hold_nopulse", lv, 0);
      letter(P_BT);
      check("b_letter", int'(LETTER), 2);
      check("b_ok_amb", ok * 10 + amb, 11);
      letter(P_C);
      check("c_letter", int'(LETTER), 3);
      check("c_ok", ok, 1);
      letter(P_A);
      letter(P_C);
      check("ac_err", err * 10 + ok, 10);
      letter(P_S);
      check("s_letter", int'(LETTER), 18);
      letter(P_BT);
      check("t_letter", int'(LETTER), 19);
      check("t_ok_amb", ok * 10 + amb, 11);
      letter(P_A);
      letter(P_BT);
      check("b2_letter", int'(LETTER), 2);
      check("b2_ok_amb", ok * 10 + amb, 11);
      letter(P_W);
      letter(P_HX);
      check("x_letter", int'(LETTER), 23);
      check("x_ok_amb", ok * 10 + amb, 11);
      check("count11", int'(LETTER_COUNT), 11);
      letter(P_Z);
      letter(P_A);
      check("wrap_ok", ok * 10 + err, 10);
      letter(P_BLANK);
      check("blank_letter", int'(LETTER), 0);
      check("blank_pulses", lv * 100 + ok * 10 + err, 100);
      letter(P_G);
      check("g_letter", int'(LETTER), 7);
      check("g_nostep", lv * 100 + ok * 10 + err, 100);
      check("count14", int'(LETTER_COUNT), 14);
      clr();
      drive(P_E, 3);
      drive(P_BAD, 1);
      drive(P_E, 4);
      repeat (3) tick();
      check("glitch_lv", lv, 1);
      check("glitch_letter", int'(LETTER), 5);
      letter(P_BAD);
      check("unk_pulse", unk * 10 + lv, 10);
      check("unk_letter", int'(LETTER), 5);
      check("unk_count", int'(LETTER_COUNT), 15);
      letter(P_F);
      check("unk_keeps_ref", ok, 1);
      clr();
      SEG_IN = P_I;
      gaps = 7'b1010011;
      for (int i = 6; i >= 0; i--) begin
         SEG_VALID = gaps[i];
         tick();
      end
      SEG_VALID = 1'b0;
      repeat (3) tick();
      check("gaps_lv", lv, 1);
      check("gaps_letter", int'(LETTER), 9);
      check("count17", int'(LETTER_COUNT), 17);
      clr();
      drive(P_J, 2);
      RESET = 1'b1;
      #2;
      check("async_count", int'(LETTER_COUNT), 0);
      check("async_letter", int'(LETTER), 0);
      repeat (2) tick();
      RESET = 1'b0;
      repeat (6) tick();
      check("rst_filter_lv", lv, 0);
      clr();
      drive(P_A, 4);
      tick();
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
      repeat (5) tick();
      check("rst_emit_lv", lv, 0);
      check("rst_emit_letter", int'(LETTER), 0);
      for (int i = 0; i < 300; i++) begin
         letter((i % 2 == 0) ? P_A : P_C);
         if (i == 99) check("count100", int'(LETTER_COUNT), 100);
      end
      check("count_sat", int'(LETTER_COUNT), 255);
      check("sat_letter", int'(LETTER), 3);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
